// File: rtl/uart_tx_serializer_if.sv
// Buffer-to-serializer bundle: pop handshake toward the TX buffer, serial line and status back out.
// The debug state field mirrors the serializer FSM encoding (0=IDLE,1=FETCH,2=START,3=DATA,4=PARITY,5=STOP).
interface uart_tx_serializer_if;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_data;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] dbg_state;

  // Handshake: fifo_rd_en is a one-cycle pop, asserted only while fifo_empty is low;
  // the popped byte appears on fifo_data on the following cycle and is consumed there.
  modport master (
    input  fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, tx_done, dbg_state
  );
  modport slave (
    output fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, tx_done, dbg_state
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops a byte from the TX buffer and shifts out start, data (LSB first), optional parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit (even, or odd with PARITY_ODD=1) between data and stop.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 done_c;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Upper buffer bits are dropped when DATA_BITS < 8; PARITY_ODD is dead without the parity build.
  logic unused_ok;
  assign unused_ok = ^{bus.fifo_data, PARITY_ODD};

  assign bit_end        = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign bus.fifo_rd_en = !rst && (state_q == S_IDLE) && !bus.fifo_empty;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.tx_done    = done_c;
  assign bus.tx         = tx_q;
  assign bus.dbg_state  = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_c   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Bit-timed states wrap the baud counter at every bit end; states only change there, so it also clears on change.
    if (state_q != S_IDLE && state_q != S_FETCH) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: begin
        shift_d  = bus.fifo_data[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
        parity_d = (^bus.fifo_data[DATA_BITS-1:0]) ^ PARITY_ODD;
`endif
        idx_d    = '0;
        cnt_d    = '0;
        tx_d     = 1'b0;
        state_d  = S_START;
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (8N1 and 7-bit/2-stop), each fed by a byte-queue buffer model,
// with a line monitor that decodes every frame cycle by cycle against a scoreboard of pushed bytes.
module tb_uart_tx_serializer;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_serializer_if if_a();
  uart_tx_serializer_if if_b();

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  logic [7:0] fq_a[$];
  logic [7:0] fq_b[$];
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  int pushes[2];
  int underflow[2];
  bit m_in[2];
  bit m_b2b[2];
  int m_cyc[2], m_len[2], m_errs[2], m_gap[2];
  int m_rdcyc[2], m_rdcnt[2], m_donecnt[2], m_frames[2], m_stray[2], m_unexp[2];
  logic [11:0] m_exp[2];
  logic [7:0] m_byte[2], m_dec[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- clock / cycle counter ----------------
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- buffer models ----------------
  always @(posedge clk) begin
    if (if_a.fifo_rd_en) begin
      if (fq_a.size() == 0) underflow[0]++;
      else if_a.fifo_data <= fq_a.pop_front();
    end
    if_a.fifo_empty <= (fq_a.size() == 0);
    if (if_b.fifo_rd_en) begin
      if (fq_b.size() == 0) underflow[1]++;
      else if_b.fifo_data <= fq_b.pop_front();
    end
    if_b.fifo_empty <= (fq_b.size() == 0);
  end

  task automatic push(input int id, input logic [7:0] b);
    pushes[id]++;
    if (id == 0) begin
      fq_a.push_back(b);
      exp_q_a.push_back(b);
    end else begin
      fq_b.push_back(b);
      exp_q_b.push_back(b);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon_step(input int id, input logic tx, input logic done, input logic busy,
                          input logic rd_en, input logic empty, input logic rstv);
    int db, sb, bit_i;
    logic odd;
    logic [7:0] eb, mask;
    db  = (id == 0) ? 8 : 7;
    sb  = (id == 0) ? 1 : 2;
    odd = (id == 0) ? 1'b0 : 1'b1;
    if (rd_en) begin
      m_rdcnt[id]++;
      m_rdcyc[id] = cyc_cnt;
    end
    if (done) m_donecnt[id]++;
    if (rstv) begin
      m_in[id]  = 1'b0;
      m_b2b[id] = 1'b0;
      m_gap[id] = 0;
      if (done) m_stray[id]++;
      return;
    end
    if (!m_in[id]) begin
      if (tx === 1'b0) begin
        eb = 8'h00;
        if (id == 0 && exp_q_a.size() > 0) eb = exp_q_a.pop_front();
        else if (id == 1 && exp_q_b.size() > 0) eb = exp_q_b.pop_front();
        else m_unexp[id]++;
        check($sformatf("latency[%0d]", id), cyc_cnt - m_rdcyc[id], 2);
        if (m_b2b[id]) check($sformatf("b2b_gap[%0d]", id), m_gap[id], 2);
        mask = 8'hFF >> (8 - db);
        m_byte[id] = eb & mask;
        m_exp[id] = '1;
        m_exp[id][0] = 1'b0;
        for (int i = 0; i < db; i++) m_exp[id][1+i] = m_byte[id][i];
        if (PB == 1) m_exp[id][1+db] = (^m_byte[id]) ^ odd;
        m_len[id]  = (1 + db + PB + sb) * CPB;
        m_cyc[id]  = 0;
        m_errs[id] = 0;
        m_dec[id]  = 8'h00;
        m_b2b[id]  = 1'b0;
        m_gap[id]  = 0;
        m_in[id]   = 1'b1;
      end else begin
        m_gap[id]++;
        if (done) m_stray[id]++;
      end
    end
    if (m_in[id]) begin
      bit_i = m_cyc[id] / CPB;
      if (tx !== m_exp[id][bit_i]) m_errs[id]++;
      if (done !== (m_cyc[id] == m_len[id] - 1)) m_errs[id]++;
      if (busy !== 1'b1) m_errs[id]++;
      if ((m_cyc[id] % CPB) == 2 && bit_i >= 1 && bit_i <= db) m_dec[id][bit_i-1] = tx;
      if (m_cyc[id] == m_len[id] - 1) begin
        check($sformatf("frame_wave[%0d]", id), m_errs[id], 0);
        check($sformatf("frame_byte[%0d]", id), m_dec[id], m_byte[id]);
        m_frames[id]++;
        m_in[id]  = 1'b0;
        m_b2b[id] = !empty;
        m_gap[id] = 0;
      end else begin
        m_cyc[id]++;
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, if_a.tx, if_a.tx_done, if_a.busy, if_a.fifo_rd_en, if_a.fifo_empty, rst);
    mon_step(1, if_b.tx, if_b.tx_done, if_b.busy, if_b.fifo_rd_en, if_b.fifo_empty, rst);
  end

  // ---------------- driver helpers ----------------
  function automatic bit drained(input int id);
    if (id == 0) return exp_q_a.size() == 0 && fq_a.size() == 0 && !if_a.busy && !m_in[0];
    return exp_q_b.size() == 0 && fq_b.size() == 0 && !if_b.busy && !m_in[1];
  endfunction

  task automatic wait_drain(input int id);
    int n = 0;
    while (n < 3000 && !drained(id)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("drain_in_time[%0d]", id), (n < 3000) ? 1 : 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", if_a.tx, 1);
    check("rst_busy", if_a.busy, 0);
    check("rst_tx_done", if_a.tx_done, 0);
    check("rst_rd_en", if_a.fifo_rd_en, 0);
    check("rst_state", if_a.dbg_state, 0);
    rst = 1'b0;

    // Empty buffer: line stays at mark, no pops.
    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (if_a.tx !== 1'b1 || if_a.busy !== 1'b0 || if_a.fifo_rd_en !== 1'b0) bad++;
    end
    check("idle_line", bad, 0);
    check("idle_pops", m_rdcnt[0], 0);

    push(0, 8'hA5);
    wait_drain(0);
    check("single_pops", m_rdcnt[0], 1);

    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h5A);
    wait_drain(0);
    check("burst_pops", m_rdcnt[0], 4);

    // Parity pair (even parity 0 for 0xA5, 1 for 0x07 in the parity build).
    push(0, 8'hA5);
    push(0, 8'h07);
    wait_drain(0);

    // Reset during DATA bit 3 of 0xC3; 0x3C stays queued and must follow cleanly.
    push(0, 8'hC3);
    push(0, 8'h3C);
    n = 0;
    while (n < 100 && if_a.tx !== 1'b0) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_start_seen", (n < 100) ? 1 : 0, 1);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx", if_a.tx, 1);
    check("abort_state", if_a.dbg_state, 0);
    check("abort_busy", if_a.busy, 0);
    rst = 1'b0;
    wait_drain(0);

    // 7 data bits, 2 stop bits; 0x95 has bit 7 set, which must not reach the line.
    push(1, 8'hFF);
    push(1, 8'h95);
    wait_drain(1);

    repeat (5) @(posedge clk);
    #1;
    check("frames[0]", m_frames[0], 7);
    check("frames[1]", m_frames[1], 2);
    check("done_count[0]", m_donecnt[0], 7);
    check("done_count[1]", m_donecnt[1], 2);
    for (int id = 0; id < 2; id++) begin
      check($sformatf("pop_count[%0d]", id), m_rdcnt[id], pushes[id]);
      check($sformatf("stray_done[%0d]", id), m_stray[id], 0);
      check($sformatf("unexpected_frame[%0d]", id), m_unexp[id], 0);
      check($sformatf("underflow[%0d]", id), underflow[id], 0);
    end
    check("leftover_a", exp_q_a.size(), 0);
    check("leftover_b", exp_q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 0);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
